matrix_result_streamer: RTL and testbench

MATRIX_RESULT_STREAMER -- requirements
Module: matrix_result_streamer

---
 rtl/matrix_result_streamer.sv | 135 +++++++++++++
 tb/tb_matrix_result_streamer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_result_streamer.sv
// Matrix result streamer: captures the packed result vector of an upstream
// matrix multiplier on the rising edge of its done flag, then streams the
// valid elements one per beat as (address, data) pairs with a valid/ready
// handshake. Element counts beyond the buffer size are clamped and flagged.
module matrix_result_streamer #(
    parameter int TYPE_BW      = 32,
    parameter int OUT_MEM_SIZE = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            arm_i,
    input  logic                            mm_done_i,
    input  logic [TYPE_BW*OUT_MEM_SIZE-1:0] mm_result_i,
    input  logic [31:0]                     count_i,
    input  logic [31:0]                     base_addr_i,
    output logic [TYPE_BW-1:0]              data_o,
    output logic [31:0]                     addr_o,
    output logic                            valid_o,
    input  logic                            ready_i,
    output logic                            last_o,
    output logic                            busy_o,
    output logic                            finished_o,
    output logic                            clamp_err_o
);

    localparam int IDX_W = (OUT_MEM_SIZE > 1) ? $clog2(OUT_MEM_SIZE) : 1;
    localparam logic [31:0]    MAX_CNT = 32'(OUT_MEM_SIZE);
    localparam logic [IDX_W:0] EFF_MAX = (IDX_W+1)'(OUT_MEM_SIZE);
    localparam logic [IDX_W:0] CNT_ONE = {{IDX_W{1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        STREAM = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic                 done_q;
    logic [31:0]          cnt_q;
    logic [31:0]          base_q;
    logic [IDX_W-1:0]     idx;
    logic [TYPE_BW-1:0]   buffer [OUT_MEM_SIZE];
    logic                 clamp_err_q;

    logic                 capture;
    logic                 is_last;
    logic [IDX_W:0]       eff_cnt;

    // Effective element count is the latched count clamped to the buffer size.
    assign eff_cnt = (cnt_q > MAX_CNT) ? EFF_MAX : cnt_q[IDX_W:0];
    // Only a low-to-high transition of done while armed triggers a capture.
    assign capture = (state_q == ARMED) && mm_done_i && !done_q;
    assign is_last = ({1'b0, idx} == (eff_cnt - CNT_ONE));
    assign clamp_err_o = clamp_err_q;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and beat outputs; outputs are zero outside their states.
    always_comb begin
        state_d    = state_q;
        valid_o    = 1'b0;
        last_o     = 1'b0;
        data_o     = '0;
        addr_o     = '0;
        busy_o     = (state_q != IDLE);
        finished_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (arm_i) state_d = ARMED;
            end
            ARMED: begin
                if (capture) state_d = (eff_cnt == '0) ? FINISH : STREAM;
            end
            STREAM: begin
                valid_o = 1'b1;
                last_o  = is_last;
                data_o  = buffer[idx];
                addr_o  = base_q + {{(32-IDX_W){1'b0}}, idx};
                if (ready_i && is_last) state_d = FINISH;
            end
            FINISH: begin
                finished_o = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Done edge detector; resets high so an upstream done held after reset
    // is not mistaken for a fresh completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_q <= 1'b1;
        end else begin
            done_q <= mm_done_i;
        end
    end

    // Job parameters, clamp flag, result snapshot and element index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            base_q      <= '0;
            idx         <= '0;
            clamp_err_q <= 1'b0;
            for (int g = 0; g < OUT_MEM_SIZE; g++) buffer[g] <= '0;
        end else begin
            if (state_q == IDLE && arm_i) begin
                cnt_q       <= count_i;
                base_q      <= base_addr_i;
                clamp_err_q <= 1'b0;
            end
            if (capture) begin
                for (int g = 0; g < OUT_MEM_SIZE; g++)
                    buffer[g] <= mm_result_i[g*TYPE_BW +: TYPE_BW];
                idx <= '0;
                if (cnt_q > MAX_CNT) clamp_err_q <= 1'b1;
            end
            if (state_q == STREAM && ready_i && !is_last) begin
                idx <= idx + IDX_ONE;
            end
        end
    end

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Directed self-checking bench for matrix_result_streamer.
module tb_matrix_result_streamer;

    localparam int TYPE_BW      = 32;
    localparam int OUT_MEM_SIZE = 16;

    logic                            clk;
    logic                            reset;
    logic                            arm_i;
    logic                            mm_done_i;
    logic [TYPE_BW*OUT_MEM_SIZE-1:0] mm_result_i;
    logic [31:0]                     count_i;
    logic [31:0]                     base_addr_i;
    logic [TYPE_BW-1:0]              data_o;
    logic [31:0]                     addr_o;
    logic                            valid_o;
    logic                            ready_i;
    logic                            last_o;
    logic                            busy_o;
    logic                            finished_o;
    logic                            clamp_err_o;

    int tests;
    int fails;

    matrix_result_streamer #(
        .TYPE_BW      (TYPE_BW),
        .OUT_MEM_SIZE (OUT_MEM_SIZE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .arm_i       (arm_i),
        .mm_done_i   (mm_done_i),
        .mm_result_i (mm_result_i),
        .count_i     (count_i),
        .base_addr_i (base_addr_i),
        .data_o      (data_o),
        .addr_o      (addr_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .last_o      (last_o),
        .busy_o      (busy_o),
        .finished_o  (finished_o),
        .clamp_err_o (clamp_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input logic [31:0] cnt, input logic [31:0] base);
        count_i     = cnt;
        base_addr_i = base;
        arm_i       = 1'b1;
        tick();
        arm_i       = 1'b0;
    endtask

    // Low then high on done: the second edge is the capture edge.
    task automatic done_edge();
        mm_done_i = 1'b0;
        tick();
        mm_done_i = 1'b1;
        tick();
    endtask

    task automatic chk_beat(input string tag, input logic [31:0] d,
                            input logic [31:0] a, input logic l);
        chk({tag, ".valid"}, {63'd0, valid_o}, 64'd1);
        chk({tag, ".data"},  {32'd0, data_o},  {32'd0, d});
        chk({tag, ".addr"},  {32'd0, addr_o},  {32'd0, a});
        chk({tag, ".last"},  {63'd0, last_o},  {63'd0, l});
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".valid"},    {63'd0, valid_o},    64'd0);
        chk({tag, ".busy"},     {63'd0, busy_o},     64'd0);
        chk({tag, ".finished"}, {63'd0, finished_o}, 64'd0);
        chk({tag, ".data"},     {32'd0, data_o},     64'd0);
        chk({tag, ".addr"},     {32'd0, addr_o},     64'd0);
        chk({tag, ".last"},     {63'd0, last_o},     64'd0);
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        reset       = 1'b0;
        arm_i       = 1'b0;
        mm_done_i   = 1'b1;
        mm_result_i = '0;
        count_i     = '0;
        base_addr_i = '0;
        ready_i     = 1'b1;

        // Reset state
        tick();
        tick();
        chk_idle("rst");
        chk("rst.clamp", {63'd0, clamp_err_o}, 64'd0);
        reset = 1'b1;
        tick();
        chk_idle("post_rst");

        // Basic stream of 4 elements at 0x100
        mm_result_i = '0;
        mm_result_i[0*32 +: 32] = 32'd5;
        mm_result_i[1*32 +: 32] = 32'd6;
        mm_result_i[2*32 +: 32] = 32'd7;
        mm_result_i[3*32 +: 32] = 32'd8;
        arm(32'd4, 32'h100);
        chk("t1.armed_busy",  {63'd0, busy_o},  64'd1);
        chk("t1.armed_valid", {63'd0, valid_o}, 64'd0);
        done_edge();
        for (int i = 0; i < 4; i++) begin
            chk_beat("t1.beat", 32'd5 + 32'(i), 32'h100 + 32'(i), (i == 3));
            tick();
        end
        chk("t1.valid_drop", {63'd0, valid_o},    64'd0);
        chk("t1.finished",   {63'd0, finished_o}, 64'd1);
        tick();
        chk("t1.fin_pulse",  {63'd0, finished_o}, 64'd0);
        chk("t1.idle_busy",  {63'd0, busy_o},     64'd0);

        // Back-pressure for 3 cycles on the second beat
        arm(32'd4, 32'h100);
        done_edge();
        for (int i = 0; i < 4; i++) begin
            chk_beat("t2.beat", 32'd5 + 32'(i), 32'h100 + 32'(i), (i == 3));
            if (i == 1) begin
                ready_i = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    chk_beat("t2.hold", 32'd6, 32'h101, 1'b0);
                end
                ready_i = 1'b1;
            end
            tick();
        end
        chk("t2.finished", {63'd0, finished_o}, 64'd1);
        tick();
        chk("t2.idle", {63'd0, busy_o}, 64'd0);

        // Count larger than buffer: 16 beats and clamp flag
        for (int g = 0; g < OUT_MEM_SIZE; g++) mm_result_i[g*32 +: 32] = 32'h10 + 32'(g);
        arm(32'd20, 32'h4000);
        chk("t3.clamp_pre", {63'd0, clamp_err_o}, 64'd0);
        done_edge();
        chk("t3.clamp_set", {63'd0, clamp_err_o}, 64'd1);
        for (int i = 0; i < 16; i++) begin
            chk_beat("t3.beat", 32'h10 + 32'(i), 32'h4000 + 32'(i), (i == 15));
            tick();
        end
        chk("t3.finished", {63'd0, finished_o}, 64'd1);
        tick();
        chk("t3.idle",        {63'd0, busy_o},      64'd0);
        chk("t3.clamp_stick", {63'd0, clamp_err_o}, 64'd1);

        // Zero count: straight to FINISH with no beat; arm clears clamp
        arm(32'd0, 32'h500);
        chk("t4.clamp_clr", {63'd0, clamp_err_o}, 64'd0);
        mm_done_i = 1'b0;
        tick();
        chk("t4.no_valid0", {63'd0, valid_o}, 64'd0);
        mm_done_i = 1'b1;
        tick();
        chk("t4.no_valid1", {63'd0, valid_o},    64'd0);
        chk("t4.finished",  {63'd0, finished_o}, 64'd1);
        tick();
        chk("t4.fin_pulse", {63'd0, finished_o}, 64'd0);
        chk("t4.idle",      {63'd0, busy_o},     64'd0);

        // Done held high through arm: no capture until a fresh edge
        mm_result_i = '0;
        mm_result_i[0*32 +: 32] = 32'hA;
        mm_result_i[1*32 +: 32] = 32'hB;
        arm(32'd2, 32'hFFFF_FFFF);
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("t5.level_novalid", {63'd0, valid_o}, 64'd0);
            chk("t5.level_armed",   {63'd0, busy_o},  64'd1);
        end
        done_edge();
        mm_result_i = {(TYPE_BW*OUT_MEM_SIZE/32){32'hDEAD_BEEF}};
        chk_beat("t5.beat0", 32'hA, 32'hFFFF_FFFF, 1'b0);
        tick();
        chk_beat("t5.beat1", 32'hB, 32'h0000_0000, 1'b1);
        tick();
        chk("t5.finished", {63'd0, finished_o}, 64'd1);
        tick();

        // Asynchronous reset mid-stream, then no beats without a new arm
        mm_result_i = '0;
        mm_result_i[0*32 +: 32] = 32'h21;
        mm_result_i[1*32 +: 32] = 32'h22;
        mm_result_i[2*32 +: 32] = 32'h23;
        mm_result_i[3*32 +: 32] = 32'h24;
        arm(32'd4, 32'h300);
        done_edge();
        tick();
        chk_beat("t6.beat2", 32'h22, 32'h301, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk_idle("t6.async");
        tick();
        chk("t6.no_finish", {63'd0, finished_o}, 64'd0);
        reset = 1'b1;
        done_edge();
        tick();
        chk_idle("t6.no_arm");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
